// File: rtl/dlatch_array.sv
// Multi-channel synchronous storage array replacing the single-bit D latch tile.
// Supports level, rise-capture, fall-capture and toggle modes, with update pulses and a saturating count.
module dlatch_array #(
    parameter int WIDTH       = 4,
    parameter int CHANNELS    = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [CHANNELS*WIDTH-1:0]    d,
    input  logic [CHANNELS-1:0]          en,
    input  logic [1:0]                   mode,
    input  logic                         freeze,
    input  logic                         clr,
    output logic [CHANNELS*WIDTH-1:0]    q,
    output logic [CHANNELS-1:0]          upd,
    output logic [7:0]                   upd_count
);

    typedef enum logic [1:0] {
        MODE_LEVEL  = 2'b00,
        MODE_RISE   = 2'b01,
        MODE_FALL   = 2'b10,
        MODE_TOGGLE = 2'b11
    } mode_e;

    logic [CHANNELS*WIDTH-1:0] d_s;
    logic [CHANNELS-1:0]       en_s;

    // Data and enable share one pipeline depth so a channel never sees
    // an enable paired with data from a different cycle.
    generate
        if (SYNC_STAGES == 0) begin : g_no_sync
            assign d_s  = d;
            assign en_s = en;
        end else begin : g_sync
            logic [CHANNELS*WIDTH-1:0] d_pipe  [SYNC_STAGES];
            logic [CHANNELS-1:0]       en_pipe [SYNC_STAGES];

            // NOTE: these are individual flops, not a RAM, so they get the
            // async reset; that is what discards in-flight samples on reset.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        d_pipe[i]  <= '0;
                        en_pipe[i] <= '0;
                    end
                end else begin
                    d_pipe[0]  <= d;
                    en_pipe[0] <= en;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        d_pipe[i]  <= d_pipe[i-1];
                        en_pipe[i] <= en_pipe[i-1];
                    end
                end
            end

            assign d_s  = d_pipe[SYNC_STAGES-1];
            assign en_s = en_pipe[SYNC_STAGES-1];
        end
    endgenerate

    logic [CHANNELS-1:0]       en_p;
    logic [CHANNELS-1:0]       rise;
    logic [CHANNELS-1:0]       fall;
    logic [CHANNELS*WIDTH-1:0] q_next;
    logic [CHANNELS-1:0]       chg;
    logic [CHANNELS-1:0]       chg_r;
    logic [7:0]                count_next;
    mode_e                     mode_q;

    assign rise   = en_s & ~en_p;
    assign fall   = ~en_s & en_p;
    assign mode_q = mode_e'(mode);

    // NOTE: every output of this block gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        q_next = q;
        for (int c = 0; c < CHANNELS; c++) begin
            if (clr) begin
                q_next[c*WIDTH +: WIDTH] = '0;
            end else if (!freeze) begin
                unique case (mode_q)
                    MODE_LEVEL: begin
                        if (en_s[c]) q_next[c*WIDTH +: WIDTH] = d_s[c*WIDTH +: WIDTH];
                    end
                    MODE_RISE: begin
                        if (rise[c]) q_next[c*WIDTH +: WIDTH] = d_s[c*WIDTH +: WIDTH];
                    end
                    MODE_FALL: begin
                        if (fall[c]) q_next[c*WIDTH +: WIDTH] = d_s[c*WIDTH +: WIDTH];
                    end
                    MODE_TOGGLE: begin
                        if (rise[c]) q_next[c*WIDTH +: WIDTH] = ~q[c*WIDTH +: WIDTH];
                    end
                endcase
            end
        end
    end

    always_comb begin
        chg = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            chg[c] = (q_next[c*WIDTH +: WIDTH] != q[c*WIDTH +: WIDTH]);
        end
    end

    // Count on the edge where q changes, so a clear that empties a
    // nonzero channel still leaves the count at zero.
    always_comb begin
        count_next = upd_count;
        if (clr) begin
            count_next = '0;
        end else if ((|chg) && (upd_count != 8'hFF)) begin
            count_next = upd_count + 8'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q         <= '0;
            en_p      <= '0;
            chg_r     <= '0;
            upd       <= '0;
            upd_count <= '0;
        end else begin
            q         <= q_next;
            en_p      <= en_s;
            chg_r     <= chg;
            upd       <= chg_r;
            upd_count <= count_next;
        end
    end

endmodule

// File: tb/tb_dlatch_array.sv
// Randomised scoreboard bench for dlatch_array: a cycle model predicts outputs,
// a negedge monitor pops predictions and compares against the DUT.
module tb_dlatch_array;

    localparam int W = 4;
    localparam int C = 2;
    localparam int S = 2;

    logic           clk    = 1'b0;
    logic           rst_n  = 1'b0;
    logic [C*W-1:0] d      = '0;
    logic [C-1:0]   en     = '0;
    logic [1:0]     mode   = 2'b00;
    logic           freeze = 1'b0;
    logic           clr    = 1'b0;
    logic [C*W-1:0] q;
    logic [C-1:0]   upd;
    logic [7:0]     upd_count;

    dlatch_array #(.WIDTH(W), .CHANNELS(C), .SYNC_STAGES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .d         (d),
        .en        (en),
        .mode      (mode),
        .freeze    (freeze),
        .clr       (clr),
        .q         (q),
        .upd       (upd),
        .upd_count (upd_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [C*W-1:0] q;
        logic [C-1:0]   upd;
        logic [7:0]     cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: stored values, last seen enable, pending pulse, count.
    logic [W-1:0]   m_q    [C];
    bit             m_enp  [C];
    bit             m_chg  [C];
    int             m_cnt;
    logic [C*W-1:0] pipe_d [$];
    logic [C-1:0]   pipe_en[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < C; c++) begin
            m_q[c]   = '0;
            m_enp[c] = 1'b0;
            m_chg[c] = 1'b0;
        end
        m_cnt = 0;
        pipe_d.delete();
        pipe_en.delete();
        for (int i = 0; i < S; i++) begin
            pipe_d.push_back('0);
            pipe_en.push_back('0);
        end
    endfunction

    // Advance the model by one rising edge using the pins as currently driven.
    function automatic exp_t model_edge();
        exp_t           e;
        logic [C*W-1:0] ds;
        logic [C-1:0]   es;
        bit             any_chg;
        e       = '0;
        any_chg = 1'b0;
        pipe_d.push_back(d);
        pipe_en.push_back(en);
        ds = pipe_d.pop_front();
        es = pipe_en.pop_front();
        for (int c = 0; c < C; c++) begin
            logic [W-1:0] nq;
            bit           rise_c;
            bit           fall_c;
            nq     = m_q[c];
            rise_c = es[c] && !m_enp[c];
            fall_c = !es[c] && m_enp[c];
            if (clr) nq = '0;
            else if (!freeze) begin
                if (mode == 2'd0 && es[c]) nq = ds[c*W +: W];
                if (mode == 2'd1 && rise_c) nq = ds[c*W +: W];
                if (mode == 2'd2 && fall_c) nq = ds[c*W +: W];
                if (mode == 2'd3 && rise_c) nq = m_q[c] ^ {W{1'b1}};
            end
            e.upd[c]      = m_chg[c];
            m_chg[c]      = (nq != m_q[c]);
            any_chg       = any_chg | m_chg[c];
            m_q[c]        = nq;
            m_enp[c]      = es[c];
            e.q[c*W +: W] = nq;
        end
        if (clr) m_cnt = 0;
        else if (any_chg && m_cnt < 255) m_cnt = m_cnt + 1;
        e.cnt = 8'(m_cnt);
        return e;
    endfunction

    task automatic step(input logic [C*W-1:0] dv, input logic [C-1:0] ev,
                        input logic [1:0] mv, input logic fz, input logic cl);
        @(negedge clk);
        #1;
        rst_n  = 1'b1;
        d      = dv;
        en     = ev;
        mode   = mv;
        freeze = fz;
        clr    = cl;
        sb.push_back(model_edge());
    endtask

    task automatic steps(input int n, input logic [C*W-1:0] dv, input logic [C-1:0] ev,
                         input logic [1:0] mv, input logic fz, input logic cl);
        for (int i = 0; i < n; i++) step(dv, ev, mv, fz, cl);
    endtask

    // Assert reset between edges and check outputs clear with no clock edge.
    task automatic do_reset();
        exp_t z;
        @(negedge clk);
        #1;
        rst_n  = 1'b0;
        d      = '0;
        en     = '0;
        freeze = 1'b0;
        clr    = 1'b0;
        #1;
        check("rst_async_q", 32'(q), 32'h0);
        check("rst_async_upd", 32'(upd), 32'h0);
        check("rst_async_cnt", 32'(upd_count), 32'h0);
        model_reset();
        z = '0;
        sb.push_back(z);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("q", 32'(q), 32'(e.q));
            check("upd", 32'(upd), 32'(e.upd));
            check("upd_count", 32'(upd_count), 32'(e.cnt));
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);

        // Load channel 0 with 0xA, then reset while enable is still in flight.
        steps(5, 8'h0A, 2'b01, 2'b00, 1'b0, 1'b0);
        step(8'h05, 2'b01, 2'b00, 1'b0, 1'b0);
        do_reset();
        steps(5, 8'h00, 2'b00, 2'b00, 1'b0, 1'b0);

        // Level mode: capture, hold while closed, identical rewrite.
        steps(6, 8'h0A, 2'b01, 2'b00, 1'b0, 1'b0);
        steps(5, 8'h05, 2'b00, 2'b00, 1'b0, 1'b0);
        steps(6, 8'h0A, 2'b01, 2'b00, 1'b0, 1'b0);
        steps(4, 8'h00, 2'b00, 2'b00, 1'b0, 1'b0);

        // Rise capture then fall capture on channel 0.
        step(8'h03, 2'b01, 2'b01, 1'b0, 1'b0);
        steps(4, 8'h0C, 2'b01, 2'b01, 1'b0, 1'b0);
        steps(3, 8'h0C, 2'b01, 2'b10, 1'b0, 1'b0);
        steps(5, 8'h0C, 2'b00, 2'b10, 1'b0, 1'b0);

        // Toggle mode: clear, then three pulses on channel 1.
        step(8'h00, 2'b00, 2'b11, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(8'h00, 2'b10, 2'b11, 1'b0, 1'b0);
            steps(3, 8'h00, 2'b00, 2'b11, 1'b0, 1'b0);
        end
        steps(4, 8'h00, 2'b00, 2'b11, 1'b0, 1'b0);

        // Freeze swallows an edge; clear under freeze still clears.
        step(8'h06, 2'b01, 2'b01, 1'b0, 1'b0);
        steps(5, 8'h06, 2'b00, 2'b01, 1'b0, 1'b0);
        step(8'h09, 2'b01, 2'b01, 1'b1, 1'b0);
        steps(5, 8'h09, 2'b00, 2'b01, 1'b1, 1'b0);
        steps(5, 8'h09, 2'b00, 2'b01, 1'b0, 1'b0);
        step(8'h09, 2'b00, 2'b01, 1'b1, 1'b1);
        steps(4, 8'h00, 2'b00, 2'b01, 1'b0, 1'b0);

        // Saturation: 300 toggle pulses on both channels.
        for (int i = 0; i < 300; i++) begin
            step(8'h00, 2'b11, 2'b11, 1'b0, 1'b0);
            step(8'h00, 2'b00, 2'b11, 1'b0, 1'b0);
        end
        steps(4, 8'h00, 2'b00, 2'b11, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        check("saturated_count", 32'(upd_count), 32'd255);
        step(8'h00, 2'b00, 2'b11, 1'b0, 1'b1);
        steps(3, 8'h00, 2'b00, 2'b11, 1'b0, 1'b0);

        // Randomised traffic with one mid-run reset.
        for (int i = 0; i < 400; i++) begin
            logic [1:0] mv;
            mv = (i % 50 == 0) ? 2'($urandom_range(0, 3)) : mode;
            if (i == 200) do_reset();
            step(8'($urandom), 2'($urandom_range(0, 3)), mv,
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 29) == 0));
        end
        steps(4, 8'h00, 2'b00, mode, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        #2;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dlatch_array.md
# dlatch_array

Parametrised, fully synchronous successor to the single-bit D latch tile: CHANNELS independent WIDTH-bit storage channels, each with its own enable. A global mode selects level-transparent, rising-capture, falling-capture or toggle behaviour. Enable and data from the pad ring pass through a configurable synchroniser. Per-channel update pulses and a saturating update counter are provided, so the tile wrapper can drive them straight to `uo_out` for observation.

## Interface
- `WIDTH`, 4: data bits per channel (1..8).
- `CHANNELS`, 2: number of independent channels (1..4).
- `SYNC_STAGES`, 2: synchroniser depth on `d` and `en` (0..3; 0 = inputs used directly).
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `d`  in  CHANNELS*WIDTH: channel c data is `d[c*WIDTH +: WIDTH]`.
- `en`  in  CHANNELS: per-channel enable.
- `mode`  in  2: global mode: 00 level, 01 rise-capture, 10 fall-capture, 11 toggle.
- `freeze`  in  1: blocks all `q` updates while high.
- `clr`  in  1: synchronous clear of `q` and `upd_count`.
- `q`  out  CHANNELS*WIDTH: stored values, registered.
- `upd`  out  CHANNELS: one-cycle pulse when that channel's `q` changed on the previous edge.
- `upd_count`  out  8: count of cycles in which any `upd` bit was set; saturates at 255.

## Operation
- Synchroniser: `d` and `en` each pass through SYNC_STAGES flops, giving `d_s` and `en_s`. The data and enable paths have equal delay.
- Edge detect: `en_p` holds `en_s` from the previous cycle and updates every cycle, including during `freeze` and `clr`.
  - rise = `en_s & ~en_p`
  - fall = `~en_s & en_p`
- Next value per channel, by priority:
  1. `clr`: `q` = 0.
  2. `freeze`: `q` held.
  3. `mode`:
     - 00: `q` = `d_s` while `en_s` = 1, else hold.
     - 01: `q` = `d_s` on rise, else hold.
     - 10: `q` = `d_s` on fall, else hold. This is master-slave behaviour: it captures the value present as the enable closes.
     - 11: `q` = ~`q` (all bits) on rise; `d_s` is ignored.
- `upd[c]` is registered: it is 1 in the cycle after the edge where `q[c]` took a value different from its old value.
  - Writing an identical value gives no pulse.
  - A `clr` of a nonzero channel does pulse `upd`.
- `upd_count`:
  - Increments by 1 on each edge where any channel's `q` changes, regardless of how many channels changed.
  - Holds at 255.
  - Cleared by `clr`. When `clr` is active it wins over the increment.
- `mode` change takes effect on the next edge. Edge-detect state is not reset, so a rise present in the same cycle as the mode switch is evaluated under the new mode.
- Edges occurring while `freeze` = 1 are lost. They are not replayed after `freeze` drops.
- Reset (`rst_n` = 0) is asynchronous. Immediately, and for as long as reset is held:
  - `q` = 0, `upd` = 0, `upd_count` = 0.
  - All synchroniser flops and `en_p` = 0.
  - A reset mid-operation discards any in-flight synchroniser contents.

## Timing
- Level mode latency, `d`/`en` pin change to `q`: SYNC_STAGES+1 rising edges.
- `upd` asserts one cycle after `q` changes and lasts exactly one cycle per change.
- Capture and toggle modes: `q` updates SYNC_STAGES+1 edges after the `en` pin transition.
- `clr` and `freeze` are not synchronised. They act on the first rising edge where they are sampled high.
- With SYNC_STAGES = 0, `d`/`en` must meet setup to `clk`.
- After `rst_n` deasserts, a held-high `en` is seen as a rise SYNC_STAGES+1 edges later.

## Test plan
All scenarios use WIDTH=4, CHANNELS=2, SYNC_STAGES=2.

1. Reset: drive `q[3:0]` to 0xA, then pulse `rst_n` low between edges. Required: `q` = 0, `upd` = 0 and `upd_count` = 0 with no clock edge. After release with `en` = 0, the outputs stay 0.
2. Level mode, channel 0:
   - `en[0]` = 1, `d[3:0]` = 0xA at edge 0 -> `q[3:0]` = 0xA after edge 3, and `upd[0]` = 1 for one cycle after edge 4.
   - Then `en[0]` = 0, `d` = 0x5 -> `q` stays 0xA.
   - Rewriting 0xA with `en[0]` = 1 -> no `upd`.
3. Capture modes, channel 0:
   - Mode 01: `en` rises with `d` = 0x3, then `d` = 0xC while `en` is high -> `q` = 0x3.
   - Switch to mode 10: `en` falls with `d` = 0xC -> `q` = 0xC.
   - Channel 1 is untouched throughout.
4. Toggle mode: three `en[1]` pulses starting from `q[7:4]` = 0 -> 0xF, 0x0, 0xF. Three `upd[1]` pulses; `upd_count` = 3.
5. Freeze and clear:
   - `en[0]` pulse while `freeze` = 1 -> `q` unchanged, no `upd`, and no replay after `freeze` drops.
   - `clr` with `freeze` = 1 -> `q` = 0 and `upd_count` = 0; `upd` pulses for the channels that were nonzero.
6. Saturation: 300 toggle pulses on both channels simultaneously -> `upd_count` increments once per update cycle and stops at 255. A following `clr` -> 0.
